des_rd_resp_split: RTL and testbench
====================================

// Module: des_rd_resp_split
// PURPOSE
// Sits between a des_ro stage that issues neighbour/offset reads and the next des_ro
// stage (resp_subtype). Forwards AR requests to memory, keeps each request's task
// context in an in-order FIFO, and splits every R burst into one task per beat
// tagged with word_id, so the consumer sees (task, subtype, data, word_id, slot).
// Memory returns R beats in AR issue order on a single ID.
// PARAMETERS
// CTX_DEPTH  8   outstanding read bursts tracked (power of 2, >=2)
// TILE_ID    0   tile index, simulation display only
// PORTS
// clk            in   1      clock
// rstn           in   1      synchronous active-low reset
// req_valid      in   1      read request from upstream stage (arvalid)
// req_ready      out  1      request accepted
// req_araddr     in   32     byte address
// req_arsize     in   3      2: 32-bit words, 3: one 64-bit word
// req_arlen      in   8      beats-1 (0..7)
// req_task       in   task_t task context copied to every resp beat
// req_subtype    in   subtype_t  subtype for resp tasks
// req_mark_last  in   1      flag last beat of burst as last
// req_cq_slot    in   cq_slice_slot_t  owning CQ slot
// m_arvalid/m_arready/m_araddr[32]/m_arsize[3]/m_arlen[8]  AR master to memory
// m_rvalid       in   1      R beat valid
// m_rready       out  1      R beat accepted
// m_rdata        in   64     beat data
// m_rlast        in   1      last beat of burst
// out_valid      out  1      split task valid
// out_ready      in   1      consumer ready
// out_task/out_subtype/out_cq_slot  out  context of owning request
// out_data       out  64     arsize 3: rdata; arsize 2: {32'b0, rdata[31:0]}
// out_word_id    out  8      beat index within burst, 0..arlen
// out_last       out  1      ctx.mark_last & (word_id == ctx.arlen)
// ctx_count      out  $clog2(CTX_DEPTH)+1  outstanding bursts
// err            out  1      sticky protocol error
// BEHAVIOUR
// - Reset: out_valid=0, m_arvalid=0, m_rready=0 during reset, ctx_count=0, err=0,
//   beat counter=0; FIFO pointers cleared. Reset mid-burst drops all context.
// - AR path combinational: m_arvalid = req_valid & ~full; req_ready = m_arready & ~full;
//   addr/size/len pass through. full = (ctx_count==CTX_DEPTH) from registered count;
//   a same-cycle pop does NOT allow a push at full.
// - On AR handshake push {task,subtype,mark_last,cq_slot,arlen,arsize}; count+1.
// - Output is one register stage: m_rready = rstn & (~out_valid | out_ready).
//   Beat accepted (m_rvalid & m_rready) with ctx non-empty -> next cycle out_valid=1,
//   fields from FIFO head, word_id=beat counter. Latency R beat -> out = 1 cycle;
//   full throughput 1 beat/cycle under out_ready=1.
// - out_valid held, fields stable, until out_ready; cleared when out_ready & no new beat.
// - Beat counter (8b) increments per accepted beat; on m_rlast: pop head, count-1,
//   counter<=0. Push and pop same cycle: count unchanged.
// - Error (err<=1, sticky until reset): rlast with counter!=arlen, or counter==arlen
//   without rlast (beat still emitted; head popped only on rlast), or beat with
//   ctx empty (beat dropped, no output).
// - FIFO pointers wrap mod CTX_DEPTH; empty/full distinguished by ctx_count.
// TESTING
// 1 arlen=3 arsize=2 mark_last=1, 4 beats rdata=0x..A0..A3, out_ready=1 -> 4 outs
//   word_id 0..3, data 0xA0..0xA3, out_last only on word 3, ctx_count 1->0.
// 2 arsize=3 arlen=0 rdata=0x0000_0010_0000_0008 -> single out, data unchanged,
//   word_id 0, out_last=mark_last.
// 3 issue CTX_DEPTH+1 requests, no R -> req_ready=0 after 8th, ctx_count=8;
//   one full burst returns -> 9th accepted next cycle.
// 4 out_ready=0 for 5 cycles mid-burst -> m_rready=0, out fields stable,
//   no beat lost/duplicated; resumes in order.
// 5 back-to-back bursts (arlen 1 then 0), second beat after rlast same cycle as push
//   -> contexts not mixed, word_id restarts at 0.
// 6 rlast on beat 1 of arlen=3 burst -> err=1, head popped; rstn low mid-burst ->
//   out_valid=0, ctx_count=0, err=0 next cycle.

Source files
------------

// File: rtl/des_rd_resp_split.sv
// Forwards AR reads, queues per-burst task context in order, and splits each R burst into one task per beat.
// R beat to task output takes one cycle; the R channel stalls whenever the output register is held by out_ready_i.
module des_rd_resp_split #(
  parameter int CTX_DEPTH = 8,
  parameter int TILE_ID   = 0,
  parameter int TASK_W    = 32,
  parameter int SUBTYPE_W = 4,
  parameter int SLOT_W    = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [31:0]                 req_araddr_i,
  input  logic [2:0]                  req_arsize_i,
  input  logic [7:0]                  req_arlen_i,
  input  logic [TASK_W-1:0]           req_task_i,
  input  logic [SUBTYPE_W-1:0]        req_subtype_i,
  input  logic                        req_mark_last_i,
  input  logic [SLOT_W-1:0]           req_cq_slot_i,
  output logic                        m_arvalid_o,
  input  logic                        m_arready_i,
  output logic [31:0]                 m_araddr_o,
  output logic [2:0]                  m_arsize_o,
  output logic [7:0]                  m_arlen_o,
  input  logic                        m_rvalid_i,
  output logic                        m_rready_o,
  input  logic [63:0]                 m_rdata_i,
  input  logic                        m_rlast_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [TASK_W-1:0]           out_task_o,
  output logic [SUBTYPE_W-1:0]        out_subtype_o,
  output logic [SLOT_W-1:0]           out_cq_slot_o,
  output logic [63:0]                 out_data_o,
  output logic [7:0]                  out_word_id_o,
  output logic                        out_last_o,
  output logic [$clog2(CTX_DEPTH):0]  ctx_count_o,
  output logic                        err_o
);

  localparam int PTR_W = $clog2(CTX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [TASK_W-1:0]    task_mem [CTX_DEPTH];
  logic [SUBTYPE_W-1:0] sub_mem  [CTX_DEPTH];
  logic [SLOT_W-1:0]    slot_mem [CTX_DEPTH];
  logic                 mark_mem [CTX_DEPTH];
  logic [7:0]           len_mem  [CTX_DEPTH];
  logic [2:0]           size_mem [CTX_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] ctx_count_q, ctx_count_d;
  logic [7:0]       beat_cnt_q, beat_cnt_d;
  logic             err_q, err_d;

  logic                 out_valid_q, out_valid_d;
  logic [TASK_W-1:0]    out_task_q, out_task_d;
  logic [SUBTYPE_W-1:0] out_sub_q, out_sub_d;
  logic [SLOT_W-1:0]    out_slot_q, out_slot_d;
  logic [63:0]          out_data_q, out_data_d;
  logic [7:0]           out_wid_q, out_wid_d;
  logic                 out_last_q, out_last_d;

  logic ctx_full, ctx_empty, push, pop, beat_acc, beat_use, at_len;

  logic [31:0] unused_tile;
  assign unused_tile = 32'(TILE_ID);

  // Full/empty come from the registered count, so a pop never frees a slot in the same cycle.
  assign ctx_full  = (ctx_count_q == CNT_W'(CTX_DEPTH));
  assign ctx_empty = (ctx_count_q == '0);

  assign m_arvalid_o = req_valid_i & ~ctx_full;
  assign req_ready_o = m_arready_i & ~ctx_full;
  assign m_araddr_o  = req_araddr_i;
  assign m_arsize_o  = req_arsize_i;
  assign m_arlen_o   = req_arlen_i;
  assign push        = m_arvalid_o & m_arready_i;

  assign m_rready_o = rstn & (~out_valid_q | out_ready_i);
  assign beat_acc   = m_rvalid_i & m_rready_o;
  assign beat_use   = beat_acc & ~ctx_empty;
  assign at_len     = (beat_cnt_q == len_mem[rd_ptr_q]);
  assign pop        = beat_use & m_rlast_i;

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    ctx_count_d = ctx_count_q;
    case ({push, pop})
      2'b10:   ctx_count_d = ctx_count_q + 1'b1;
      2'b01:   ctx_count_d = ctx_count_q - 1'b1;
      default: ctx_count_d = ctx_count_q;
    endcase

    beat_cnt_d = beat_cnt_q;
    if (beat_use) beat_cnt_d = m_rlast_i ? 8'd0 : beat_cnt_q + 8'd1;

    // Length mismatch in either direction, or a beat with no owning request.
    err_d = err_q | (beat_acc & ctx_empty) | (beat_use & (m_rlast_i ^ at_len));

    out_valid_d = out_valid_q;
    out_task_d  = out_task_q;
    out_sub_d   = out_sub_q;
    out_slot_d  = out_slot_q;
    out_data_d  = out_data_q;
    out_wid_d   = out_wid_q;
    out_last_d  = out_last_q;
    if (beat_use) begin
      out_valid_d = 1'b1;
      out_task_d  = task_mem[rd_ptr_q];
      out_sub_d   = sub_mem[rd_ptr_q];
      out_slot_d  = slot_mem[rd_ptr_q];
      out_data_d  = (size_mem[rd_ptr_q] == 3'd3) ? m_rdata_i : {32'h0, m_rdata_i[31:0]};
      out_wid_d   = beat_cnt_q;
      out_last_d  = mark_mem[rd_ptr_q] & at_len;
    end else if (out_ready_i) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      task_mem[wr_ptr_q] <= req_task_i;
      sub_mem[wr_ptr_q]  <= req_subtype_i;
      slot_mem[wr_ptr_q] <= req_cq_slot_i;
      mark_mem[wr_ptr_q] <= req_mark_last_i;
      len_mem[wr_ptr_q]  <= req_arlen_i;
      size_mem[wr_ptr_q] <= req_arsize_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ctx_count_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_task_q  <= '0;
      out_sub_q   <= '0;
      out_slot_q  <= '0;
      out_data_q  <= '0;
      out_wid_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ctx_count_q <= ctx_count_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_task_q  <= out_task_d;
      out_sub_q   <= out_sub_d;
      out_slot_q  <= out_slot_d;
      out_data_q  <= out_data_d;
      out_wid_q   <= out_wid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid_o   = out_valid_q;
  assign out_task_o    = out_task_q;
  assign out_subtype_o = out_sub_q;
  assign out_cq_slot_o = out_slot_q;
  assign out_data_o    = out_data_q;
  assign out_word_id_o = out_wid_q;
  assign out_last_o    = out_last_q;
  assign ctx_count_o   = ctx_count_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_des_rd_resp_split.sv
// Directed bench for des_rd_resp_split: queue-based reference model checked every cycle, plus literal spot checks.
module tb_des_rd_resp_split;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_mark_last;
  logic [31:0] req_araddr;
  logic [2:0]  req_arsize;
  logic [7:0]  req_arlen;
  logic [31:0] req_task;
  logic [3:0]  req_subtype, req_cq_slot;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arsize;
  logic [7:0]  m_arlen;
  logic        m_rvalid, m_rready, m_rlast;
  logic [63:0] m_rdata;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_task;
  logic [3:0]  out_subtype, out_cq_slot;
  logic [63:0] out_data;
  logic [7:0]  out_word_id;
  logic [3:0]  ctx_count;
  logic        err;

  des_rd_resp_split dut (
    .clk(clk), .rstn(rstn),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_araddr_i(req_araddr),
    .req_arsize_i(req_arsize), .req_arlen_i(req_arlen), .req_task_i(req_task),
    .req_subtype_i(req_subtype), .req_mark_last_i(req_mark_last), .req_cq_slot_i(req_cq_slot),
    .m_arvalid_o(m_arvalid), .m_arready_i(m_arready), .m_araddr_o(m_araddr),
    .m_arsize_o(m_arsize), .m_arlen_o(m_arlen),
    .m_rvalid_i(m_rvalid), .m_rready_o(m_rready), .m_rdata_i(m_rdata), .m_rlast_i(m_rlast),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_task_o(out_task),
    .out_subtype_o(out_subtype), .out_cq_slot_o(out_cq_slot), .out_data_o(out_data),
    .out_word_id_o(out_word_id), .out_last_o(out_last), .ctx_count_o(ctx_count), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] tsk; logic [3:0] sub; logic [3:0] slot;
    logic mark; logic [7:0] len; logic [2:0] size;
  } ctx_t;
  typedef struct packed {
    logic [31:0] tsk; logic [3:0] sub; logic [3:0] slot;
    logic [63:0] data; logic [7:0] wid; logic last;
  } out_t;

  int   vec_n = 0;
  int   miss_n = 0;
  ctx_t ctxq[$];
  out_t exp_q[$];
  out_t obs[$];
  int   beatn = 0;
  logic err_m = 1'b0;
  bit   armed = 1'b0;
  ctx_t c;
  out_t e, a;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
    vec_n++;
    if (act !== expv) begin
      miss_n++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, expv, $time);
    end
  endfunction

  // Reference model: checks current outputs, then applies the handshakes of the coming edge.
  always @(negedge clk) begin
    a = {out_task, out_subtype, out_cq_slot, out_data, out_word_id, out_last};
    if (armed && rstn) begin
      chk("out_valid", out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) chk("out_fields", a, exp_q[0]);
      chk("ctx_count", ctx_count, ctxq.size());
      chk("err", err, err_m);
      chk("m_rready", m_rready, (exp_q.size() == 0) || out_ready);
      chk("req_ready", req_ready, m_arready && ctxq.size() < 8);
      chk("m_arvalid", m_arvalid, req_valid && ctxq.size() < 8);
      chk("ar_pass", {m_araddr, m_arsize, m_arlen}, {req_araddr, req_arsize, req_arlen});
    end
    if (!rstn) begin
      ctxq.delete(); exp_q.delete(); beatn = 0; err_m = 1'b0; armed = 1'b1;
    end else if (armed) begin
      if (out_valid && out_ready) begin
        obs.push_back(a);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (m_rvalid && m_rready) begin
        if (ctxq.size() == 0) err_m = 1'b1;
        else begin
          c = ctxq[0];
          e.tsk = c.tsk; e.sub = c.sub; e.slot = c.slot;
          e.data = (c.size == 3'd3) ? m_rdata : {32'h0, m_rdata[31:0]};
          e.wid = 8'(beatn);
          e.last = c.mark && (beatn == int'(c.len));
          exp_q.push_back(e);
          if (m_rlast) begin
            if (beatn != int'(c.len)) err_m = 1'b1;
            void'(ctxq.pop_front());
            beatn = 0;
          end else begin
            if (beatn == int'(c.len)) err_m = 1'b1;
            beatn++;
          end
        end
      end
      if (req_valid && req_ready)
        ctxq.push_back({req_task, req_subtype, req_cq_slot, req_mark_last, req_arlen, req_arsize});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_ar(input logic [7:0] len, input logic [2:0] size, input logic mark,
                         input logic [31:0] tsk, input logic [3:0] slot);
    bit acc = 0;
    req_valid = 1; req_arlen = len; req_arsize = size; req_mark_last = mark;
    req_task = tsk; req_subtype = tsk[3:0]; req_cq_slot = slot; req_araddr = {tsk[23:0], 8'h40};
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk); acc = req_ready; step();
    end
    req_valid = 0;
    if (!acc) chk("ar_timeout", 0, 1);
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    bit acc = 0;
    m_rvalid = 1; m_rdata = d; m_rlast = last;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk); acc = m_rready; step();
    end
    m_rvalid = 0; m_rlast = 0;
    if (!acc) chk("r_timeout", 0, 1);
  endtask

  task automatic chk_obs(input int idx, input logic [31:0] tsk, input logic [63:0] d,
                         input logic [7:0] wid, input logic last);
    if (idx < obs.size()) chk("obs_item", {obs[idx].tsk, obs[idx].data, obs[idx].wid, obs[idx].last},
                              {tsk, d, wid, last});
    else chk("obs_missing", obs.size(), idx + 1);
  endtask

  int base;

  initial begin
    rstn = 0; req_valid = 0; req_araddr = 0; req_arsize = 0; req_arlen = 0; req_task = 0;
    req_subtype = 0; req_mark_last = 0; req_cq_slot = 0; m_arready = 1;
    m_rvalid = 0; m_rdata = 0; m_rlast = 0; out_ready = 1;
    repeat (3) step();
    chk("rst_m_rready", m_rready, 0);
    rstn = 1; step();
    chk("rst_state", {out_valid, ctx_count, err}, 0);

    // 1: 32-bit burst of four, upper data bits must be cleared
    base = obs.size();
    send_ar(8'd3, 3'd2, 1'b1, 32'h11, 4'd2);
    chk("t1_count1", ctx_count, 1);
    for (int i = 0; i < 4; i++) send_beat(64'hFFFF_FFFF_0000_00A0 + 64'(i), i == 3);
    step(); step();
    chk("t1_count0", ctx_count, 0);
    for (int i = 0; i < 4; i++) chk_obs(base + i, 32'h11, 64'hA0 + 64'(i), 8'(i), i == 3);

    // 2: single 64-bit beat, mark_last clear
    base = obs.size();
    send_ar(8'd0, 3'd3, 1'b0, 32'h22, 4'd1);
    send_beat(64'h0000_0010_0000_0008, 1'b1);
    step();
    chk_obs(base, 32'h22, 64'h0000_0010_0000_0008, 8'd0, 1'b0);

    // 3: fill the context FIFO, ninth request waits for one pop
    base = obs.size();
    for (int i = 0; i < 8; i++) send_ar(8'd0, 3'd3, 1'b1, 32'h30 + 32'(i), 4'd3);
    chk("t3_full", ctx_count, 8);
    req_valid = 1; req_task = 32'h38; req_subtype = 4'h8; req_arlen = 0; req_arsize = 3; req_mark_last = 1;
    for (int i = 0; i < 3; i++) begin step(); chk("t3_blocked", req_ready, 0); end
    m_rvalid = 1; m_rdata = 64'h100; m_rlast = 1;
    step();
    m_rvalid = 0; m_rlast = 0;
    chk("t3_freed", req_ready, 1);
    step();
    req_valid = 0;
    chk("t3_refill", ctx_count, 8);
    for (int i = 1; i < 9; i++) send_beat(64'h100 + 64'(i), 1'b1);
    step();
    for (int i = 0; i < 9; i++) chk_obs(base + i, 32'h30 + 32'(i), 64'h100 + 64'(i), 8'd0, 1'b1);

    // 4: consumer stalls mid-burst
    base = obs.size();
    send_ar(8'd3, 3'd3, 1'b1, 32'h40, 4'd4);
    send_beat(64'h200, 0);
    send_beat(64'h201, 0);
    out_ready = 0;
    m_rvalid = 1; m_rdata = 64'h202;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_stall_rready", m_rready, 0);
      chk("t4_hold", {out_valid, out_data, out_word_id}, {1'b1, 64'h201, 8'd1});
    end
    out_ready = 1;
    send_beat(64'h202, 0);
    send_beat(64'h203, 1);
    step();
    for (int i = 0; i < 4; i++) chk_obs(base + i, 32'h40, 64'h200 + 64'(i), 8'(i), i == 3);

    // 5: rlast and next push in the same cycle
    base = obs.size();
    send_ar(8'd1, 3'd2, 1'b1, 32'h50, 4'd5);
    send_beat(64'hB0, 0);
    req_valid = 1; req_arlen = 0; req_arsize = 2; req_mark_last = 1; req_task = 32'h51; req_subtype = 1;
    m_rvalid = 1; m_rdata = 64'hB1; m_rlast = 1;
    step();
    req_valid = 0; m_rvalid = 0; m_rlast = 0;
    chk("t5_count", ctx_count, 1);
    send_beat(64'hC0, 1);
    step();
    chk_obs(base, 32'h50, 64'hB0, 8'd0, 1'b0);
    chk_obs(base + 1, 32'h50, 64'hB1, 8'd1, 1'b1);
    chk_obs(base + 2, 32'h51, 64'hC0, 8'd0, 1'b1);

    // 6: early rlast, then reset mid-burst
    base = obs.size();
    send_ar(8'd3, 3'd2, 1'b1, 32'h60, 4'd6);
    send_beat(64'hD0, 0);
    send_beat(64'hD1, 1);
    step();
    chk("t6_err", {err, ctx_count}, {1'b1, 4'd0});
    chk_obs(base + 1, 32'h60, 64'hD1, 8'd1, 1'b0);
    send_ar(8'd3, 3'd2, 1'b1, 32'h61, 4'd6);
    send_beat(64'hE0, 0);
    rstn = 0;
    step();
    chk("t6_rst_rready", m_rready, 0);
    chk("t6_rst", {out_valid, ctx_count, err}, 0);
    rstn = 1; step();

    // 7: beat with no context is dropped; beat at arlen without rlast keeps the head
    base = obs.size();
    send_beat(64'hF0, 1);
    step();
    chk("t7_orphan", {err, out_valid}, {1'b1, 1'b0});
    rstn = 0; step(); rstn = 1; step();
    base = obs.size();
    send_ar(8'd0, 3'd3, 1'b1, 32'h70, 4'd7);
    send_beat(64'hF1, 0);
    chk("t7_nolast", {err, ctx_count}, {1'b1, 4'd1});
    send_beat(64'hF2, 1);
    step();
    chk("t7_pop", ctx_count, 0);
    chk_obs(base, 32'h70, 64'hF1, 8'd0, 1'b1);
    chk_obs(base + 1, 32'h70, 64'hF2, 8'd1, 1'b0);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
